// File: rtl/bcd_ctrl_pkg.sv
// Shared encodings for the BCD counter controller: FSM states, arbitrated
// commands and the BCD digit limits.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_WAIT_REL
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DOWN,
    CMD_SET0,
    CMD_SET9
  } cmd_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the cascade. Loads apply unconditionally; steps only when
// every lower digit is at its wrap value (signalled through en).
module bcd_digit_cell
  import bcd_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  cmd_t       cmd,
  input  logic       en,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  logic [3:0] r_digit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_digit <= BCD_MIN;
    end else begin
      case (cmd)
        CMD_SET0: r_digit <= BCD_MIN;
        CMD_SET9: r_digit <= BCD_MAX;
        CMD_UP:   if (en) r_digit <= (r_digit == BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
        CMD_DOWN: if (en) r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
        default:  r_digit <= r_digit;
      endcase
    end
  end

  assign digit  = r_digit;
  assign at_max = (r_digit == BCD_MAX);
  assign at_min = (r_digit == BCD_MIN);

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Button front end and sequencer for a DIGITS-wide BCD up/down counter:
// synchronisers, priority arbitration, auto-repeat FSM and wrap flags.
module bcd_counter_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int RPT_CYCLES  = 10_000_000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  up,
  input  logic                  down,
  input  logic                  set9,
  input  logic                  set0,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  repeating
);

  localparam int CNT_MAX = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYCLES - 1);

  logic [3:0]       r_sync1, r_sync2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir_up;
  logic             r_repeating;
  logic             r_overflow, r_underflow;

  logic w_s_up, w_s_down, w_s_set9, w_s_set0;
  logic w_load, w_dir_lvl, w_opp_lvl, w_cnt_hit;
  cmd_t w_cmd, w_load_cmd, w_dir_cmd;

  logic [DIGITS:0]     w_all_max, w_all_min;
  logic [DIGITS-1:0]   w_at_max, w_at_min, w_en;
  logic [4*DIGITS-1:0] w_digits;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {set0, set9, down, up};
      r_sync2 <= r_sync1;
    end
  end

  assign w_s_up   = r_sync2[0];
  assign w_s_down = r_sync2[1];
  assign w_s_set9 = r_sync2[2];
  assign w_s_set0 = r_sync2[3];

  assign w_load     = w_s_set0 | w_s_set9;
  assign w_load_cmd = w_s_set0 ? CMD_SET0 : CMD_SET9;
  assign w_dir_cmd  = r_dir_up ? CMD_UP : CMD_DOWN;
  assign w_dir_lvl  = r_dir_up ? w_s_up : w_s_down;
  assign w_opp_lvl  = r_dir_up ? w_s_down : w_s_up;
  assign w_cnt_hit  = (r_state == ST_HOLD) ? (r_cnt == HOLD_LAST) : (r_cnt == RPT_LAST);

  // Command is decoded combinationally so the cells act on the same edge the FSM moves.
  always_comb begin
    w_cmd = CMD_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_load)                     w_cmd = w_load_cmd;
        else if (w_s_up && !w_s_down)   w_cmd = CMD_UP;
        else if (w_s_down && !w_s_up)   w_cmd = CMD_DOWN;
      end
      ST_HOLD, ST_REPEAT: begin
        if (w_load)                                    w_cmd = w_load_cmd;
        else if (w_dir_lvl && !w_opp_lvl && w_cnt_hit) w_cmd = w_dir_cmd;
      end
      default: w_cmd = CMD_NONE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dir_up    <= 1'b0;
      r_repeating <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_load || (w_s_up && w_s_down)) begin
            r_state <= ST_WAIT_REL;
          end else if (w_s_up || w_s_down) begin
            r_state  <= ST_HOLD;
            r_dir_up <= w_s_up;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (w_load || w_opp_lvl || !w_dir_lvl) begin
            r_state     <= (!w_load && !w_dir_lvl) ? ST_IDLE : ST_WAIT_REL;
            r_repeating <= 1'b0;
          end else if (w_cnt_hit) begin
            r_cnt       <= '0;
            r_state     <= ST_REPEAT;
            r_repeating <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_REL: begin
          if (!(w_s_up || w_s_down || w_load)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (w_cmd == CMD_UP)   && w_all_max[DIGITS];
      r_underflow <= (w_cmd == CMD_DOWN) && w_all_min[DIGITS];
    end
  end

  assign w_all_max[0] = 1'b1;
  assign w_all_min[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_all_max[g+1] = w_all_max[g] & w_at_max[g];
    assign w_all_min[g+1] = w_all_min[g] & w_at_min[g];
    assign w_en[g] = (w_cmd == CMD_UP)   ? w_all_max[g] :
                     (w_cmd == CMD_DOWN) ? w_all_min[g] : 1'b1;

    bcd_digit_cell u_cell (
      .clock   (clock),
      .reset_n (reset_n),
      .cmd     (w_cmd),
      .en      (w_en[g]),
      .digit   (w_digits[4*g +: 4]),
      .at_max  (w_at_max[g]),
      .at_min  (w_at_min[g])
    );
  end

  assign digits    = w_digits;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign repeating = r_repeating;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed bench for bcd_counter_ctrl with DIGITS=2, HOLD_CYCLES=8, RPT_CYCLES=3.
module tb_bcd_counter_ctrl;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       up      = 1'b0;
  logic       down    = 1'b0;
  logic       set9    = 1'b0;
  logic       set0    = 1'b0;
  logic [7:0] digits;
  logic       overflow, underflow, repeating;

  int total = 0;
  int bad   = 0;

  bcd_counter_ctrl #(
    .DIGITS      (2),
    .HOLD_CYCLES (8),
    .RPT_CYCLES  (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .up        (up),
    .down      (down),
    .set9      (set9),
    .set0      (set0),
    .digits    (digits),
    .overflow  (overflow),
    .underflow (underflow),
    .repeating (repeating)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press_up(input int n);
    repeat (n) begin
      up = 1'b1; tick(2); up = 1'b0; tick(4);
    end
  endtask

  task automatic press_down(input int n);
    repeat (n) begin
      down = 1'b1; tick(2); down = 1'b0; tick(4);
    end
  endtask

  task automatic do_set0();
    set0 = 1'b1; tick(2); set0 = 1'b0; tick(4);
  endtask

  task automatic do_set9();
    set9 = 1'b1; tick(2); set9 = 1'b0; tick(4);
  endtask

  initial begin
    // power-on reset
    tick(2);
    chk("rst_digits", 32'(digits), 32'h00);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    chk("rst_rep", 32'(repeating), 32'd0);
    reset_n = 1'b1;
    tick(3);
    chk("post_rst_idle", 32'(digits), 32'h00);

    // scenario 1: count to 37, async reset between edges
    press_up(37);
    chk("s1_count37", 32'(digits), 32'h37);
    reset_n = 1'b0;
    #1;
    chk("s1_async_digits", 32'(digits), 32'h00);
    chk("s1_async_ovf", 32'(overflow), 32'd0);
    chk("s1_async_unf", 32'(underflow), 32'd0);
    chk("s1_async_rep", 32'(repeating), 32'd0);
    #1 reset_n = 1'b1;
    tick(6);
    chk("s1_no_step", 32'(digits), 32'h00);

    // scenario 2: up held 4 cycles gives exactly one step at k+2
    do_set0();
    up = 1'b1;
    tick(2);
    chk("s2_lat_k1", 32'(digits), 32'h00);
    tick(1);
    chk("s2_step_k2", 32'(digits), 32'h01);
    chk("s2_rep_lo", 32'(repeating), 32'd0);
    tick(1);
    up = 1'b0;
    tick(10);
    chk("s2_one_step", 32'(digits), 32'h01);
    chk("s2_rep_stays", 32'(repeating), 32'd0);

    // scenario 3: overflow / underflow pulses
    do_set9();
    chk("s3_set9", 32'(digits), 32'h99);
    up = 1'b1; tick(2); up = 1'b0;
    chk("s3_ovf_before", 32'(overflow), 32'd0);
    tick(1);
    chk("s3_wrap_up", 32'(digits), 32'h00);
    chk("s3_ovf_pulse", 32'(overflow), 32'd1);
    tick(1);
    chk("s3_ovf_drop", 32'(overflow), 32'd0);
    tick(4);
    down = 1'b1; tick(2); down = 1'b0;
    tick(1);
    chk("s3_wrap_dn", 32'(digits), 32'h99);
    chk("s3_unf_pulse", 32'(underflow), 32'd1);
    chk("s3_ovf_quiet", 32'(overflow), 32'd0);
    tick(1);
    chk("s3_unf_drop", 32'(underflow), 32'd0);
    tick(4);

    // scenario 4: auto-repeat schedule T, T+8, T+11, T+14, T+17
    do_set0();
    up = 1'b1;
    for (int t = 1; t <= 23; t++) begin
      tick(1);
      case (t)
        3:  begin chk("s4_T", 32'(digits), 32'h01); chk("s4_T_rep", 32'(repeating), 32'd0); end
        10: begin chk("s4_T7", 32'(digits), 32'h01); chk("s4_T7_rep", 32'(repeating), 32'd0); end
        11: begin chk("s4_T8", 32'(digits), 32'h02); chk("s4_T8_rep", 32'(repeating), 32'd1); end
        13: chk("s4_T10", 32'(digits), 32'h02);
        14: chk("s4_T11", 32'(digits), 32'h03);
        17: chk("s4_T14", 32'(digits), 32'h04);
        20: begin chk("s4_T17", 32'(digits), 32'h05); up = 1'b0; end
        21: chk("s4_rel1_rep", 32'(repeating), 32'd1);
        22: begin chk("s4_rel2_rep", 32'(repeating), 32'd1); chk("s4_rel2_dig", 32'(digits), 32'h05); end
        23: begin chk("s4_rel3_rep", 32'(repeating), 32'd0); chk("s4_final", 32'(digits), 32'h05); end
        default: ;
      endcase
    end
    tick(4);

    // scenario 5: carry and borrow across digits
    do_set0();
    press_up(19);
    chk("s5_19", 32'(digits), 32'h19);
    press_up(1);
    chk("s5_carry_20", 32'(digits), 32'h20);
    press_down(1);
    chk("s5_borrow_19", 32'(digits), 32'h19);
    do_set0();
    press_up(9);
    chk("s5_09", 32'(digits), 32'h09);
    press_up(1);
    chk("s5_carry_10", 32'(digits), 32'h10);

    // scenario 6a: up and down together, then lockout until both released
    up = 1'b1; down = 1'b1;
    tick(4);
    chk("s6a_both", 32'(digits), 32'h10);
    down = 1'b0;
    tick(6);
    chk("s6a_lockout", 32'(digits), 32'h10);
    up = 1'b0;
    tick(4);
    chk("s6a_released", 32'(digits), 32'h10);
    press_up(1);
    chk("s6a_fresh", 32'(digits), 32'h11);

    // scenario 6b: set0 during REPEAT at 07
    do_set0();
    up = 1'b1;
    tick(26);
    chk("s6b_07", 32'(digits), 32'h07);
    chk("s6b_rep_on", 32'(repeating), 32'd1);
    set0 = 1'b1;
    tick(2);
    chk("s6b_k1", 32'(digits), 32'h07);
    tick(1);
    chk("s6b_load", 32'(digits), 32'h00);
    chk("s6b_rep_off", 32'(repeating), 32'd0);
    set0 = 1'b0;
    tick(10);
    chk("s6b_no_steps", 32'(digits), 32'h00);
    up = 1'b0;
    tick(4);
    press_up(1);
    chk("s6b_after", 32'(digits), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_ctrl.md
# bcd_counter_ctrl

Push-button front end and sequencer for a multi-digit BCD up/down counter. Four raw button levels (up, down, set9, set0) are synchronised and arbitrated into single commands with fixed priority. Held up/down buttons generate auto-repeat steps. The controller drives a cascade of `DIGITS` BCD digit cells with ripple carry/borrow, which makes it the block between the board switches and the seven-segment display driver.

## Interface
- `DIGITS`, 2: number of BCD digits in the cascade (1..8).
- `HOLD_CYCLES`, 50_000_000: cycles from first step to first auto-repeat step (≥2).
- `RPT_CYCLES`, 10_000_000: cycles between auto-repeat steps (≥2).
- `clock` input 1: single clock, rising edge.
- `reset_n` input 1: one clock; reset is asynchronous and active-low.
- `up` input 1: raw button level, asynchronous to `clock`.
- `down` input 1: raw button level, asynchronous.
- `set9` input 1: raw button level, asynchronous; loads all digits to 9.
- `set0` input 1: raw button level, asynchronous; loads all digits to 0.
- `digits` output 4*DIGITS: packed BCD value, digit 0 at LSBs; registered.
- `overflow` output 1: one-cycle pulse on up-wrap from all 9s to all 0s.
- `underflow` output 1: one-cycle pulse on down-wrap from all 0s to all 9s.
- `repeating` output 1: high while the FSM is in REPEAT.

## Operation
- **Synchronisation.** Each button passes through a 2-FF synchroniser. The FSM sees only the synchronised levels (`s_up`, `s_down`, `s_set9`, `s_set0`).
- **Priority in IDLE:** set0 > set9 > up/down. Both `s_up` and `s_down` high together is a no-op and goes to WAIT_REL.
- **IDLE**
  - set0: load 0s, go to WAIT_REL.
  - set9: load 9s, go to WAIT_REL.
  - up only: step +1, latch dir=UP, cnt=0, go to HOLD.
  - down only: step −1, latch dir=DOWN, cnt=0, go to HOLD.
- **HOLD / REPEAT**, checked in this order each cycle:
  - `s_set0` or `s_set9` high: apply the load (set0 wins), go to WAIT_REL.
  - Latched-direction button low: go to IDLE with no step. The IDLE rules then apply on the next cycle.
  - Opposite direction high: go to WAIT_REL with no step.
  - Otherwise increment cnt.
    - In HOLD, cnt==HOLD_CYCLES−1: step, cnt=0, go to REPEAT.
    - In REPEAT, cnt==RPT_CYCLES−1: step, cnt=0.
- **WAIT_REL:** stay until all four synchronised levels are low, then go to IDLE. No steps are taken in this state.
- **Cascade**
  - On an up step, digit i increments iff all lower digits equal 9. A digit at 9 wraps to 0.
  - On a down step, digit i decrements iff all lower digits equal 0. A digit at 0 wraps to 9.
  - `overflow` fires when every digit was 9 on an up step. `underflow` fires when every digit was 0 on a down step.
- **Illegal digit values.** Digit values 10–15 never occur: loads only write 0 or 9.
- **Held through reset.** A button held through reset release is treated as a fresh press once it is synchronised.

## Timing
- **Reset values.** Asynchronous assertion forces:
  - `digits`=0, `overflow`=0, `underflow`=0, `repeating`=0;
  - state=IDLE, cnt=0, synchroniser FFs=0.
- **Reset mid-operation** aborts any repeat immediately. Nothing else is held over.
- **Latency.** A button level stable before edge k appears in `digits` at edge k+2. Release is seen at the same latency.
- **Pulse outputs.** `overflow`/`underflow` are registered, high for exactly the one cycle in which the wrapped value is first visible.
- **Repeat schedule.** For a first step at edge T, steps occur at T, T+HOLD_CYCLES, then every RPT_CYCLES after that.
  - `repeating` rises at T+HOLD_CYCLES.
  - `repeating` falls on the edge the FSM leaves REPEAT.
- **Step rate.** At most one step or load per cycle.

## Structure
- **Package `bcd_ctrl_pkg`** holds:
  - state encoding (IDLE, HOLD, REPEAT, WAIT_REL);
  - command encoding (CMD_NONE, CMD_UP, CMD_DOWN, CMD_SET0, CMD_SET9);
  - constants BCD_MAX=4'd9 and BCD_MIN=4'd0.
- **Sub-module `bcd_digit_cell`**, one instance per digit via generate.
  - Inputs: `clock`, `reset_n`, `cmd`, `en`.
  - Outputs: the 4-bit digit, plus combinational `at_max`/`at_min` used to build the enables of the digits above it.
- **Top level** holds the synchronisers, FSM, repeat counter and flag registers.

## Test plan
All scenarios use `DIGITS`=2, `HOLD_CYCLES`=8, `RPT_CYCLES`=3.
1. Count to 0x37, then pulse `reset_n` low between clock edges -> `digits`=0x00 immediately; all flags 0. After release, no step occurs until a button is pressed.
2. `set0`, release, then `up` held 4 cycles -> exactly one step; `digits`=0x01 at edge k+2; `repeating` stays 0.
3. `set9` -> 0x99; up press -> 0x00 with `overflow`=1 for one cycle; down press -> 0x99 with `underflow`=1 for one cycle.
4. From 0x00, hold `up` 20 cycles -> steps at T, T+8, T+11, T+14, T+17; final `digits`=0x05; `repeating` high from T+8 until release +2 cycles.
5. Carry and borrow: 0x19 up -> 0x20; 0x20 down -> 0x19; 0x09 up -> 0x10.
6. Simultaneous events:
   - `up` and `down` rising together -> no change; a new press is ignored until both are released.
   - `set0` asserted at 0x07 during REPEAT -> 0x00 two edges later; no further steps while `up` is still held.
